cpu_debug_ctrl: RTL

Run/halt/single-step debug controller for the 5-stage pipelined CPU. It is the driving end of the CPU's `break`/`continue` debug inputs. It turns raw board buttons into debounced commands and gates pipeline advance. It also halts the CPU on a PC breakpoint. It sits beside the CPU top level and feeds its break/continue pins.

---
 rtl/cpu_debug_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cpu_debug_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_debug_ctrl : run/halt/single-step/breakpoint debug controller      |
// |                  driving the CPU break/continue pins from board keys.  |
// | Revision       : 1.0                                                   |
// +-----------------------------------------------------------------------+
module cpu_debug_ctrl #(
   parameter int unsigned DB_CYCLES = 16,
   parameter bit          RESET_RUN = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_run,
   input  logic        btn_step,
   input  logic        btn_halt,
   input  logic [7:0]  step_cnt,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   input  logic [31:0] pc,
   output logic        cpu_break,
   output logic        cpu_continue,
   output logic [1:0]  dbg_state,
   output logic [31:0] run_cycles
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] c_db_max = CW'(DB_CYCLES);

   typedef enum logic [1:0] {
      ST_HALT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_BP_HIT = 2'd3
   } state_e;

   // Button index: 0 run, 1 step, 2 halt
   logic [2:0] btn_raw;
   logic [2:0] ev_raw;

   assign btn_raw = {btn_halt, btn_step, btn_run};

   for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic          sync1_q;
      logic          sync2_q;
      logic [CW-1:0] cnt_q;
      logic          lvl_prev_q;
      logic          lvl;

      assign lvl = (cnt_q == c_db_max);

      always_ff @(posedge clk) begin
         if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cnt_q      <= '0;
            lvl_prev_q <= 1'b0;
         end else begin
            sync1_q    <= btn_raw[gi];
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl;
            if (!sync2_q)
               cnt_q <= '0;
            else if (cnt_q != c_db_max)
               cnt_q <= cnt_q + 1'b1;
         end
      end

      assign ev_raw[gi] = lvl & ~lvl_prev_q;
   end

   state_e      state_q;
   logic [7:0]  rem_q;
   logic        armed_q;
   logic [1:0]  pend_q;     // {step, run} caught in the STEP exit cycle
   logic [31:0] run_cycles_q;

   logic        bp_match;
   logic        bp_hit;
   logic        go_halt;
   logic        go_step;
   logic        go_run;
   logic [7:0]  step_load_d;

   assign bp_match    = (pc == bp_addr);
   assign bp_hit      = bp_en & armed_q & bp_match;
   assign step_load_d = (step_cnt == 8'd0) ? 8'd1 : step_cnt;

   assign go_halt = ev_raw[2];
   assign go_step = (ev_raw[1] | pend_q[1]) & ~go_halt;
   assign go_run  = (ev_raw[0] | pend_q[0]) & ~go_halt & ~go_step;

   assign cpu_break    = (state_q != ST_RUN) | bp_hit;
   assign cpu_continue = (state_q == ST_STEP) & (rem_q != 8'd0);
   assign dbg_state    = state_q;
   assign run_cycles   = run_cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RESET_RUN ? ST_RUN : ST_HALT;
         rem_q        <= 8'd0;
         armed_q      <= 1'b1;
         pend_q       <= 2'b00;
         run_cycles_q <= 32'd0;
      end else begin
         pend_q <= 2'b00;
         if (!bp_match)
            armed_q <= 1'b1;
         if (!cpu_break)
            run_cycles_q <= run_cycles_q + 32'd1;

         case (state_q)
            ST_HALT: begin
               if (go_step) begin
                  rem_q   <= step_load_d;
                  state_q <= ST_STEP;
               end else if (go_run) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (go_halt)
                  state_q <= ST_HALT;
               else if (bp_hit)
                  state_q <= ST_BP_HIT;
            end
            ST_STEP: begin
               if (go_halt) begin
                  rem_q   <= 8'd0;
                  state_q <= ST_HALT;
               end else begin
                  if (rem_q != 8'd0)
                     rem_q <= rem_q - 8'd1;
                  // Last pulse: leave now, replay any command seen here in HALT
                  if (rem_q <= 8'd1) begin
                     state_q <= ST_HALT;
                     pend_q  <= {go_step, go_run};
                  end
               end
            end
            ST_BP_HIT: begin
               if (go_halt) begin
                  state_q <= ST_HALT;
               end else if (go_step) begin
                  armed_q <= ~bp_match;
                  rem_q   <= step_load_d;
                  state_q <= ST_STEP;
               end else if (go_run) begin
                  armed_q <= ~bp_match;
                  state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_HALT;
         endcase
      end
   end

endmodule
`default_nettype wire
